// File: rtl/conv1d_pkg.sv
// Shared encodings and index widths for the third-layer CONV1D RAM sequencer.
package conv1d_pkg;

  localparam int CH_IDX_W  = 4;
  localparam int POS_IDX_W = 8;
  localparam int MAX_CH    = 16;
  localparam int MAX_LEN   = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic                 first;
    logic                 last;
    logic [POS_IDX_W-1:0] pos;
  } tap_t;

endpackage

// File: rtl/conv1d_idx_counter.sv
// Two-level nested index counter: inner wraps at inner_max and carries into outer.
module conv1d_idx_counter
  import conv1d_pkg::*;
#(
  parameter int IN_W  = CH_IDX_W,
  parameter int OUT_W = POS_IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic [IN_W-1:0]  inner_max,
  input  logic [OUT_W-1:0] outer_max,
  output logic [IN_W-1:0]  inner,
  output logic [OUT_W-1:0] outer,
  output logic             last
);

  logic [IN_W-1:0]  inner_q, inner_d;
  logic [OUT_W-1:0] outer_q, outer_d;

  always_comb begin
    inner_d = inner_q;
    outer_d = outer_q;
    if (clr) begin
      inner_d = '0;
      outer_d = '0;
    end else if (en) begin
      if (inner_q == inner_max) begin
        inner_d = '0;
        outer_d = (outer_q == outer_max) ? '0 : outer_q + OUT_W'(1);
      end else begin
        inner_d = inner_q + IN_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inner_q <= '0;
      outer_q <= '0;
    end else begin
      inner_q <= inner_d;
      outer_q <= outer_d;
    end
  end

  assign inner = inner_q;
  assign outer = outer_q;
  assign last  = (inner_q == inner_max) && (outer_q == outer_max);

endmodule

// File: rtl/conv1d_3rd_ram_ctrl.sv
// Load/read sequencer for the layer-3 CONV1D data RAM; drives all RAM strobes and tap flags.
//   state   | meaning
//   IDLE    | waiting for start
//   LOAD    | accepting stream, registered RAM writes
//   COMPUTE | one registered read per cycle, channel inner
//   DRAIN   | waiting RD_LAT cycles for the last tap, then done
module conv1d_3rd_ram_ctrl
  import conv1d_pkg::*;
#(
  parameter int Bit_width = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [4:0]           cfg_ch,
  input  logic [8:0]           cfg_len,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Bit_width-1:0] in_data,
  output logic                 Write_Enable,
  output logic [3:0]           Write_Depth,
  output logic [7:0]           Write_Width,
  output logic [Bit_width-1:0] data_in,
  output logic                 Read_Enable,
  output logic [3:0]           Read_Depth,
  output logic [7:0]           Read_Width,
  output logic                 tap_valid,
  output logic                 tap_first_ch,
  output logic                 tap_last_ch,
  output logic [7:0]           tap_pos,
  output logic                 busy,
  output logic                 done
);

  state_t                 state_q, state_d;
  logic [CH_IDX_W-1:0]    ch_max_q, ch_max_d;
  logic [POS_IDX_W-1:0]   len_max_q, len_max_d;
  logic                   wr_en_q, wr_en_d;
  logic [CH_IDX_W-1:0]    wr_depth_q, wr_depth_d;
  logic [POS_IDX_W-1:0]   wr_width_q, wr_width_d;
  logic [Bit_width-1:0]   wr_data_q, wr_data_d;
  logic                   rd_en_q, rd_en_d;
  logic [CH_IDX_W-1:0]    rd_depth_q, rd_depth_d;
  logic [POS_IDX_W-1:0]   rd_width_q, rd_width_d;
  logic                   rd_first_q, rd_first_d;
  logic                   rd_last_q, rd_last_d;
  logic [1:0]             drain_cnt_q, drain_cnt_d;
  logic                   done_q, done_d;
  tap_t                   pipe_q [RD_LAT];
  tap_t                   pipe_d [RD_LAT];

  logic                   wr_inc, rd_inc, wr_clr, rd_clr, wr_last, rd_last_all;
  logic [CH_IDX_W-1:0]    wr_ch, rd_ch;
  logic [POS_IDX_W-1:0]   wr_pos, rd_pos;

  conv1d_idx_counter #(.IN_W(CH_IDX_W), .OUT_W(POS_IDX_W)) u_wr_cnt (
    .CLK(CLK), .RST(RST), .clr(wr_clr), .en(wr_inc),
    .inner_max(ch_max_q), .outer_max(len_max_q),
    .inner(wr_ch), .outer(wr_pos), .last(wr_last)
  );

  conv1d_idx_counter #(.IN_W(CH_IDX_W), .OUT_W(POS_IDX_W)) u_rd_cnt (
    .CLK(CLK), .RST(RST), .clr(rd_clr), .en(rd_inc),
    .inner_max(ch_max_q), .outer_max(len_max_q),
    .inner(rd_ch), .outer(rd_pos), .last(rd_last_all)
  );

  // Counters are zeroed whenever the state they belong to is not (or no longer) active.
  assign wr_clr = (state_d != LOAD);
  assign rd_clr = (state_d != COMPUTE);

  always_comb begin
    state_d     = state_q;
    ch_max_d    = ch_max_q;
    len_max_d   = len_max_q;
    wr_en_d     = 1'b0;
    wr_depth_d  = wr_depth_q;
    wr_width_d  = wr_width_q;
    wr_data_d   = wr_data_q;
    rd_en_d     = 1'b0;
    rd_depth_d  = rd_depth_q;
    rd_width_d  = rd_width_q;
    rd_first_d  = 1'b0;
    rd_last_d   = 1'b0;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    wr_inc      = 1'b0;
    rd_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ch == 5'd0 || cfg_len == 9'd0) begin
            done_d = 1'b1;
          end else begin
            ch_max_d  = cfg_ch[3:0] - 4'd1;
            len_max_d = cfg_len[7:0] - 8'd1;
            state_d   = LOAD;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          wr_inc     = 1'b1;
          wr_en_d    = 1'b1;
          wr_depth_d = wr_ch;
          wr_width_d = wr_pos;
          wr_data_d  = in_data;
          if (wr_last) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        rd_inc     = 1'b1;
        rd_en_d    = 1'b1;
        rd_depth_d = rd_ch;
        rd_width_d = rd_pos;
        rd_first_d = (rd_ch == '0);
        rd_last_d  = (rd_ch == ch_max_q);
        if (rd_last_all) begin
          state_d     = DRAIN;
          drain_cnt_d = 2'(RD_LAT);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == 2'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      wr_en_d = 1'b0;
      rd_en_d = 1'b0;
      done_d  = 1'b0;
      wr_inc  = 1'b0;
      rd_inc  = 1'b0;
    end
  end

  // Tap flags are the issued read sideband delayed to line up with RAM data_out.
  always_comb begin
    pipe_d[0] = '{valid: rd_en_q, first: rd_first_q, last: rd_last_q, pos: rd_width_q};
    for (int k = 1; k < RD_LAT; k++) pipe_d[k] = pipe_q[k-1];
    if (abort && state_q != IDLE) begin
      for (int k = 0; k < RD_LAT; k++) pipe_d[k] = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      ch_max_q    <= '0;
      len_max_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_depth_q  <= '0;
      wr_width_q  <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_depth_q  <= '0;
      rd_width_q  <= '0;
      rd_first_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      ch_max_q    <= ch_max_d;
      len_max_q   <= len_max_d;
      wr_en_q     <= wr_en_d;
      wr_depth_q  <= wr_depth_d;
      wr_width_q  <= wr_width_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_depth_q  <= rd_depth_d;
      rd_width_q  <= rd_width_d;
      rd_first_q  <= rd_first_d;
      rd_last_q   <= rd_last_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
      for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign in_ready     = (state_q == LOAD);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign Write_Enable = wr_en_q;
  assign Write_Depth  = wr_depth_q;
  assign Write_Width  = wr_width_q;
  assign data_in      = wr_data_q;
  assign Read_Enable  = rd_en_q;
  assign Read_Depth   = rd_depth_q;
  assign Read_Width   = rd_width_q;
  assign tap_valid    = pipe_q[RD_LAT-1].valid;
  assign tap_first_ch = pipe_q[RD_LAT-1].first;
  assign tap_last_ch  = pipe_q[RD_LAT-1].last;
  assign tap_pos      = pipe_q[RD_LAT-1].pos;

endmodule

// File: tb/tb_conv1d_3rd_ram_ctrl.sv
// Bench for conv1d_3rd_ram_ctrl: logs every strobe and compares against sequences computed arithmetically.
module tb_conv1d_3rd_ram_ctrl;
  localparam int BW     = 16;
  localparam int RD_LAT = 1;

  logic          CLK = 1'b0;
  logic          RST, start, abort, in_valid;
  logic [4:0]    cfg_ch;
  logic [8:0]    cfg_len;
  logic [BW-1:0] in_data;
  logic          in_ready, Write_Enable, Read_Enable, tap_valid, tap_first_ch, tap_last_ch, busy, done;
  logic [3:0]    Write_Depth, Read_Depth;
  logic [7:0]    Write_Width, Read_Width, tap_pos;
  logic [BW-1:0] data_in;

  conv1d_3rd_ram_ctrl #(.Bit_width(BW), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RST(RST), .start(start), .cfg_ch(cfg_ch), .cfg_len(cfg_len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .Write_Enable(Write_Enable), .Write_Depth(Write_Depth), .Write_Width(Write_Width), .data_in(data_in),
    .Read_Enable(Read_Enable), .Read_Depth(Read_Depth), .Read_Width(Read_Width),
    .tap_valid(tap_valid), .tap_first_ch(tap_first_ch), .tap_last_ch(tap_last_ch), .tap_pos(tap_pos),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int x; int y; int z; int cyc; } ev_t;
  ev_t wq[$];
  ev_t rq[$];
  ev_t tq[$];
  int  dq[$];
  logic [BW-1:0] src [4096];

  typedef struct { int c; int l; int mode; bit seq; int inj; int exp_lat; } vec_t;
  vec_t vecs [9];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (Write_Enable) wq.push_back('{int'(Write_Depth), int'(Write_Width), int'(data_in), cyc});
    if (Read_Enable)  rq.push_back('{int'(Read_Depth), int'(Read_Width), 0, cyc});
    if (tap_valid)    tq.push_back('{int'(tap_first_ch), int'(tap_last_ch), int'(tap_pos), cyc});
    if (done)         dq.push_back(cyc);
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    wq.delete(); rq.delete(); tq.delete(); dq.delete();
  endtask

  task automatic check_job(int c, int l, int s, int mode, int exp_lat);
    int n, bad;
    n = (c == 0 || l == 0) ? 0 : c * l;
    chk("wr_count", wq.size(), n);
    bad = -1;
    for (int i = 0; i < n && i < wq.size(); i++)
      if (bad < 0 && (wq[i].x != i % c || wq[i].y != i / c || wq[i].z != int'(src[i]))) bad = i;
    chk("wr_seq_first_bad", bad, -1);
    chk("rd_count", rq.size(), n);
    bad = -1;
    for (int i = 0; i < n && i < rq.size(); i++)
      if (bad < 0 && (rq[i].x != i % c || rq[i].y != i / c || rq[i].cyc != rq[0].cyc + i)) bad = i;
    chk("rd_seq_first_bad", bad, -1);
    chk("tap_count", tq.size(), n);
    bad = -1;
    for (int i = 0; i < n && i < tq.size() && i < rq.size(); i++)
      if (bad < 0 && (tq[i].x != int'(i % c == 0) || tq[i].y != int'(i % c == c - 1) ||
                      tq[i].z != i / c || tq[i].cyc != rq[i].cyc + RD_LAT)) bad = i;
    chk("tap_seq_first_bad", bad, -1);
    if (n > 0 && wq.size() == n && rq.size() > 0)
      chk("rd_after_last_wr", rq[0].cyc, wq[n-1].cyc + 1);
    if (mode == 1 && n > 1 && wq.size() == n)
      chk("wr_gap_span", wq[n-1].cyc - wq[0].cyc, 2 * (n - 1));
    chk("done_count", dq.size(), 1);
    if (dq.size() > 0) begin
      if (exp_lat >= 0) chk("done_latency", dq[0] - s, exp_lat);
      else if (tq.size() > 0) chk("done_after_last_tap", dq[0], tq[tq.size()-1].cyc + 1);
    end
    @(negedge CLK);
    chk("idle_after_done", int'(busy), 0);
  endtask

  task automatic run_job(int c, int l, int mode, bit seq, int inj, int exp_lat);
    int n, k, s, budget;
    bit acc, seen;
    n = (c == 0 || l == 0) ? 0 : c * l;
    for (int i = 0; i < n; i++) src[i] = seq ? BW'(i + 1) : BW'($urandom);
    @(posedge CLK); #1;
    clear_logs();
    start = 1'b1; cfg_ch = 5'(c); cfg_len = 9'(l); in_valid = 1'b0; s = cyc;
    @(posedge CLK); #1;
    start = 1'b0; cfg_ch = 5'($urandom); cfg_len = 9'($urandom);
    k = 0; seen = 1'b0; budget = 4 * n + 20;
    for (int t = 1; t < budget && !seen; t++) begin
      if (inj > 0 && cyc == s + inj) begin
        start = 1'b1; cfg_ch = 5'd1; cfg_len = 9'd1;
      end else start = 1'b0;
      case (mode)
        0:       in_valid = (k < n);
        1:       in_valid = (k < n) && t[0];
        default: in_valid = (k < n) && ($urandom_range(0, 1) == 1);
      endcase
      in_data = (k < n) ? src[k] : BW'($urandom);
      @(negedge CLK);
      acc  = in_valid && in_ready;
      seen = done;
      @(posedge CLK); #1;
      if (acc) k++;
    end
    start = 1'b0; in_valid = 1'b0;
    chk("done_seen_in_budget", int'(seen), 1);
    check_job(c, l, s, mode, exp_lat);
  endtask

  initial begin
    int k, c, l;
    bit any;
    RST = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    cfg_ch = '0; cfg_len = '0; in_data = '0;
    #1;
    any = in_ready | Write_Enable | Read_Enable | tap_valid | busy | done | (|Write_Depth) |
          (|Write_Width) | (|data_in) | (|Read_Depth) | (|Read_Width) | tap_first_ch | tap_last_ch | (|tap_pos);
    chk("reset_outputs_zero", int'(any), 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;

    vecs[0] = '{2,   3,   0, 1'b1, 0, 2*6 + RD_LAT + 2};
    vecs[1] = '{2,   3,   1, 1'b1, 0, -1};
    vecs[2] = '{16,  256, 0, 1'b0, 0, 2*4096 + RD_LAT + 2};
    vecs[3] = '{2,   3,   0, 1'b0, 9, 2*6 + RD_LAT + 2};
    vecs[4] = '{0,   5,   0, 1'b0, 0, 1};
    vecs[5] = '{3,   0,   0, 1'b0, 0, 1};
    vecs[6] = '{1,   1,   0, 1'b0, 0, 2 + RD_LAT + 2};
    vecs[7] = '{1,   7,   0, 1'b0, 0, 14 + RD_LAT + 2};
    vecs[8] = '{16,  1,   2, 1'b0, 0, -1};
    for (int v = 0; v < 9; v++)
      run_job(vecs[v].c, vecs[v].l, vecs[v].mode, vecs[v].seq, vecs[v].inj, vecs[v].exp_lat);

    for (int r = 0; r < 4; r++) begin
      c = $urandom_range(1, 16);
      l = $urandom_range(1, 24);
      run_job(c, l, 2, 1'b0, 0, -1);
    end

    // abort after five accepted samples in LOAD
    @(posedge CLK); #1;
    clear_logs();
    start = 1'b1; cfg_ch = 5'd4; cfg_len = 9'd4;
    @(posedge CLK); #1;
    start = 1'b0;
    k = 0;
    for (int t = 0; t < 20 && k < 5; t++) begin
      in_valid = 1'b1; in_data = BW'($urandom);
      @(negedge CLK);
      if (in_ready) k++;
      @(posedge CLK); #1;
    end
    chk("abort_accepts_before", k, 5);
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0; in_valid = 1'b0;
    @(negedge CLK);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_wr_en", int'(Write_Enable), 0);
    repeat (5) @(negedge CLK);
    chk("abort_no_done", dq.size(), 0);
    chk("abort_wr_count", wq.size(), 5);
    run_job(2, 2, 0, 1'b0, 0, 2*4 + RD_LAT + 2);

    // asynchronous reset in the middle of COMPUTE
    @(posedge CLK); #1;
    clear_logs();
    start = 1'b1; cfg_ch = 5'd3; cfg_len = 9'd4;
    @(posedge CLK); #1;
    start = 1'b0;
    k = 0; any = 1'b0;
    for (int t = 0; t < 60 && !any; t++) begin
      in_valid = (k < 12); in_data = BW'($urandom);
      @(negedge CLK);
      if (in_valid && in_ready) k++;
      any = Read_Enable;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    chk("pre_reset_reading", int'(Read_Enable), 1);
    #2 RST = 1'b1;
    #1;
    any = in_ready | Write_Enable | Read_Enable | tap_valid | busy | done | (|Read_Depth) |
          (|Read_Width) | tap_first_ch | tap_last_ch | (|tap_pos);
    chk("async_reset_outputs_zero", int'(any), 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
    chk("post_reset_idle", int'(busy), 0);
    repeat (4) @(negedge CLK);
    chk("post_reset_no_done", dq.size(), 0);
    run_job(3, 2, 0, 1'b0, 0, 2*6 + RD_LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv1d_3rd_ram_ctrl.md
Name: conv1d_3rd_ram_ctrl

Overview:
Sequencer for the third-layer CONV1D data RAM (16 channels x 256 positions, two 8-channel banks). It accepts a feature-map stream from the previous layer and writes it into the RAM. It then issues one read per cycle, position-major with channel inner, and flags each returned 3-tap triple to the downstream MAC array. It owns every RAM Write_*/Read_* control line; the RAM holds no sequencing logic.

Parameters:
Bit_width, 16, sample width
RD_LAT, 1, RAM read latency in cycles (Read_Enable to data_out_0..2 valid), range 1..3

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; latches cfg_ch/cfg_len when in IDLE
cfg_ch  in  5  channel count, 1..16
cfg_len  in  9  position count, 1..256
abort  in  1  synchronous; returns to IDLE
in_valid  in  1  input sample valid
in_ready  out  1  input sample accepted when in_valid && in_ready
in_data  in  Bit_width  input sample
Write_Enable  out  1  RAM write strobe
Write_Depth  out  4  RAM channel index
Write_Width  out  8  RAM position index
data_in  out  Bit_width  RAM write data
Read_Enable  out  1  RAM read strobe
Read_Depth  out  4  RAM channel index
Read_Width  out  8  RAM position index
tap_valid  out  1  RAM data_out_0..2 valid this cycle
tap_first_ch  out  1  with tap_valid: channel 0 of a position (clear accumulator)
tap_last_ch  out  1  with tap_valid: last channel of a position (emit result)
tap_pos  out  8  position of the current tap triple
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when a job completes

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE. This is asynchronous and holds for the duration of RST.
- Stored config: cfg_ch-1 and cfg_len-1 latched as ch_max (4b) and len_max (8b). start with cfg_ch==0 or cfg_len==0 causes no writes or reads and a done pulse the next cycle.
- start outside IDLE is ignored. abort has priority over all other events in all states except IDLE. After abort: next cycle IDLE, all strobes 0, no done, RAM contents undefined.
- FSM states: IDLE, LOAD, COMPUTE, DRAIN.
- IDLE -> LOAD on a valid start.
- LOAD:
  - in_ready=1.
  - Counters wr_ch (inner, 0..ch_max) and wr_pos (outer, 0..len_max) advance only on accept.
  - Registered write: an accept in cycle N produces Write_Enable=1, Write_Depth=wr_ch, Write_Width=wr_pos, data_in=in_data in cycle N+1.
  - in_valid gaps produce Write_Enable=0 cycles.
  - Accepting ch_max/len_max drops in_ready the next cycle and moves to COMPUTE.
- COMPUTE:
  - The first Read_Enable falls in the cycle after the final Write_Enable. This guarantees write-before-read.
  - One read per cycle with no bubbles, rd_ch inner, rd_pos outer.
  - Read_Depth/Read_Width/Read_Enable are registered.
  - After issuing (ch_max, len_max): Read_Enable=0 and move to DRAIN.
  - Exactly cfg_ch*cfg_len reads are issued.
- DRAIN: waits RD_LAT cycles for the last tap. done=1 in the cycle after the last tap_valid, then IDLE.
- Tap pipeline: tap_valid, tap_first_ch (rd_ch==0), tap_last_ch (rd_ch==ch_max) and tap_pos are Read_Enable and its sideband delayed by RD_LAT registers. When cfg_ch==1, first and last are both 1.
- Counter width rules:
  - 16 channels = 4-bit counter 0..15.
  - 256 positions = 8-bit counter 0..255.
  - Terminal detection compares against ch_max/len_max. Counters never rely on overflow.
  - Both counters reset to 0 at each state entry.
- Bank selection (Depth<8 vs >=8) belongs to the RAM; this block drives the full 4-bit index.
- Job cycle count, ideal stream, from the start cycle: 1 (IDLE->LOAD) + C*L + 1 + C*L + RD_LAT + 1. A done pulse occurs on that cycle.

Decomposition:
- Shared package conv1d_pkg: state encoding (IDLE/LOAD/COMPUTE/DRAIN), CH_IDX_W=4, POS_IDX_W=8, MAX_CH=16, MAX_LEN=256.
- One sub-module: conv1d_idx_counter. It is a 2-level nested counter (inner/outer, enable, clear, max values, terminal flag) and is instantiated twice, for write and read.
- The RD_LAT delay line stays inline.

Test Plan:
1. cfg_ch=2, cfg_len=3, continuous in_valid with data 1..6 -> writes (d,w)=(0,0)(1,0)(0,1)(1,1)(0,2)(1,2) with data 1..6; reads in the same order. tap_first_ch on reads 0,2,4; tap_last_ch on reads 1,3,5; done at cycle 1+6+1+6+RD_LAT+1.
2. Same job with in_valid toggling every other cycle -> identical write sequence with Write_Enable gaps; no read starts before the final write.
3. cfg_ch=16, cfg_len=256 -> 4096 writes and 4096 reads; last read Depth=15, Width=255; tap_pos wraps to 255 and never reaches 256; done exactly once.
4. start while busy in COMPUTE, and start with cfg_ch=0 -> first is ignored with no config change; second gives no strobes and done one cycle later.
5. abort during LOAD after 5 accepts -> in_ready=0 and IDLE the next cycle; no done. A new start then runs from (0,0).
6. RST asserted mid-COMPUTE asynchronously between edges -> all outputs 0 immediately; IDLE after release; no done.
